flog_sched: RTL and testbench
=============================

# flog_sched

Front-end controller for the shared iterative mantissa-log engine `philo`. It accepts bfloat16 operands from `NREQ` requesters and grants one at a time, round-robin. Special values are resolved locally; normal operands have their 1.M mantissa launched into `philo`. The fixed-point log2 result is returned with the requester ID on a single valid/ready response bus. The block sits between the requesters and the one `philo` instance in the flog datapath.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, ≥2.
- `TIMEOUT`, 64: maximum WAIT cycles before the engine is declared hung, must exceed `OUT_WIDTH_PHILO`+2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  requester i has an operand.
- `req_data`  in  16*NREQ  bfloat16 operand of requester i at [16i+15:16i].
- `req_ready`  out  NREQ  one-hot grant; the operand is consumed in this cycle.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_id`  out  $clog2(NREQ)  index of the requester that owns the result.
- `resp_int`  out  8  signed integer part of log2, equal to exp−127.
- `resp_frac`  out  OUT_WIDTH_PHILO  fractional part, log2(1.M) from the engine.
- `resp_class`  out  2  00 normal, 01 −inf (±0 or subnormal), 10 +inf, 11 NaN (NaN in, or negative nonzero).
- `resp_err`  out  1  engine timeout; the result fields are invalid.
- `busy`  out  1  FSM not in IDLE.

## Operation
- FSM states and transitions:
  - IDLE → (grant, special operand) RESP.
  - IDLE → (grant, normal operand) LAUNCH → WAIT.
  - WAIT → (`eng_out_valid`) RESP.
  - WAIT → (timeout) FLUSH → RESP.
  - RESP → (`resp_valid`&`resp_ready`) IDLE.
- Arbitration happens only in IDLE. Round-robin search starts at `last_grant`+1 and wraps at NREQ−1→0. `last_grant` updates only on a grant; reset value is NREQ−1, so requester 0 wins first. No grant occurs outside IDLE, so `req_ready`=0 there.
- Operand decode (sign s, exp e, man m):
  - e=0 → class 01 (covers −0 and subnormals).
  - e=255 & m=0 & s=0 → class 10.
  - e=255 & m≠0 → class 11.
  - s=1 & e≠0 → class 11.
  - Otherwise normal.
- Special results: `resp_int`=0, `resp_frac`=0. The engine is not launched.
- Normal path:
  - Engine input is {1'b1, m[6:0], (MAN_WIDTH_PHILO−8)'b0}.
  - LAUNCH drives `eng_in_valid`=1 for exactly one cycle.
  - In WAIT the controller latches `eng_output_value` into `resp_frac` in the cycle `eng_out_valid`=1.
  - `resp_int`=e−127, computed as 9-bit signed and truncated to 8 bits; it is always in range for normals.
- Timeout: the WAIT counter starts at 0 on WAIT entry. If it reaches TIMEOUT−1 without `eng_out_valid`:
  - go to FLUSH for one cycle and drive the engine reset (engine `rst` = `rst` | flush);
  - the response carries `resp_err`=1, class 11, `resp_frac`=0.
- Response fields are registered and held stable while `resp_valid`=1 & `resp_ready`=0.

## Timing
- Grant in cycle T. The special path gives `resp_valid` at T+1.
- Normal path:
  - LAUNCH at T+1.
  - Engine DONE (`eng_out_valid`) at T+2+OUT_WIDTH_PHILO.
  - `resp_valid` at T+3+OUT_WIDTH_PHILO, i.e. T+19 with the package value of 16.
- The response handshake completes at cycle R. The FSM is in IDLE at R+1 and the next grant can occur at R+1.
- Simultaneous requests: exactly one `req_ready` bit is high per grant cycle. A requester that keeps `req_valid` asserted waits at most NREQ−1 other grants.
- Reset values, applied asynchronously:
  - `req_ready`=0, `resp_valid`=0, `resp_id`=0, `resp_int`=0, `resp_frac`=0, `resp_class`=0, `resp_err`=0, `busy`=0.
  - State IDLE, `last_grant`=NREQ−1.
- Reset mid-operation drops the pending response. The engine is reset together with the controller.

## Structure
- Added to `flog_pkg`:
  - ctrl state enum `ss_sched` with IDLE, LAUNCH, WAIT, FLUSH, RESP;
  - class codes `CLS_NORM`, `CLS_NINF`, `CLS_PINF`, `CLS_NAN`;
  - `BF16_EXP_W`=8, `BF16_MAN_W`=7, `EXP_BIAS`=127.
- Sub-module `flog_rr_arb`: combinational round-robin arbiter, inputs req vector and `last_grant`, outputs a one-hot grant and its index.
- `philo` is instantiated inside `flog_sched`.

## Test plan
- Requester 2 sends 0x3F80 (1.0) → `resp_id`=2, `resp_int`=0, `resp_frac`=0, class 00, `resp_valid` at grant+19.
- Requester 0 sends 0x4040 (3.0) → `resp_int`=1, `resp_frac` within 2 LSB of 0x95C0, class 00.
- All four requesters hold valid with normal operands → grants in the order 0,1,2,3,0, and each `req_ready` is a single-cycle pulse.
- Specials, each checking that `resp_valid` is high one cycle after grant and that `eng_in_valid` never rises:
  - 0x0000 → class 01;
  - 0x8000 → class 01;
  - 0x7F80 → class 10;
  - 0x7FC0 → class 11;
  - 0xBF80 → class 11.
- `resp_ready` held low for 10 cycles → all response outputs stable, `req_ready`=0 throughout. The next grant occurs the cycle after the handshake.
- Async `rst` pulse in mid-WAIT → outputs at reset values immediately, `busy`=0. A following request of 0x4000 returns `resp_int`=1, `resp_frac`=0. Separately, forcing `eng_out_valid` low → `resp_err`=1 after TIMEOUT WAIT cycles.

Source files
------------

// File: rtl/flog_pkg.sv
// rtl/flog_pkg.sv - shared types, widths and bf16 classification for the flog datapath
package flog_pkg;

  localparam int MAN_WIDTH_PHILO = 16;
  localparam int OUT_WIDTH_PHILO = 16;
  localparam int BF16_EXP_W      = 8;
  localparam int BF16_MAN_W      = 7;
  localparam int EXP_BIAS        = 127;

  localparam logic [1:0] CLS_NORM = 2'b00;
  localparam logic [1:0] CLS_NINF = 2'b01;
  localparam logic [1:0] CLS_PINF = 2'b10;
  localparam logic [1:0] CLS_NAN  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    FLUSH,
    RESP
  } ss_sched;

  // -inf + (-0/subnormal) share CLS_NINF; any negative nonzero is NaN for a log.
  function automatic logic [1:0] bf16_class(input logic [15:0] op);
    logic                  s;
    logic [BF16_EXP_W-1:0] e;
    logic [BF16_MAN_W-1:0] m;
    s = op[15];
    e = op[14:7];
    m = op[6:0];
    if (e == '0)
      return CLS_NINF;
    else if (e == '1 && m == '0 && !s)
      return CLS_PINF;
    else if (e == '1 || s)
      return CLS_NAN;
    else
      return CLS_NORM;
  endfunction

endpackage

// File: rtl/flog_rr_arb.sv
// rtl/flog_rr_arb.sv - combinational round-robin arbiter searching from last_grant+1
module flog_rr_arb #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_grant,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_idx,
  output logic                    gnt_any
);

  localparam int IW = $clog2(NREQ);

  logic [IW:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = {1'b0, last_grant} + (IW+1)'(i);
      if (cand >= (IW+1)'(NREQ))
        cand = cand - (IW+1)'(NREQ);
      if (!gnt_any && req[cand[IW-1:0]]) begin
        gnt_any              = 1'b1;
        gnt[cand[IW-1:0]]    = 1'b1;
        gnt_idx              = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/philo.sv
// rtl/philo.sv - iterative log2(1.M) engine, one result bit per cycle by repeated squaring
module philo
  import flog_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [MAN_WIDTH_PHILO-1:0] in_value,
  output logic                       out_valid,
  output logic [OUT_WIDTH_PHILO-1:0] output_value
);

  localparam int XW = 32;
  localparam int CW = $clog2(OUT_WIDTH_PHILO);

  logic [XW-1:0]   x;
  logic [2*XW-1:0] sq;
  logic [CW-1:0]   cnt;
  logic            run;

  assign sq = (2*XW)'(x) * (2*XW)'(x);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run          <= 1'b0;
      cnt          <= '0;
      x            <= '0;
      out_valid    <= 1'b0;
      output_value <= '0;
    end else begin
      out_valid <= 1'b0;
      if (!run) begin
        if (in_valid) begin
          run          <= 1'b1;
          cnt          <= '0;
          x            <= {in_value, {(XW-MAN_WIDTH_PHILO){1'b0}}};
          output_value <= '0;
        end
      end else begin
        // Discarded low product bits are jammed into the LSB so truncation bias stays tiny.
        if (sq[2*XW-1]) begin
          x            <= {sq[2*XW-1:XW+1], sq[XW] | (|sq[XW-1:0])};
          output_value <= {output_value[OUT_WIDTH_PHILO-2:0], 1'b1};
        end else begin
          x            <= {sq[2*XW-2:XW], sq[XW-1] | (|sq[XW-2:0])};
          output_value <= {output_value[OUT_WIDTH_PHILO-2:0], 1'b0};
        end
        cnt <= cnt + CW'(1);
        if (cnt == CW'(OUT_WIDTH_PHILO-1)) begin
          run       <= 1'b0;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/flog_sched.sv
// rtl/flog_sched.sv - round-robin front end that resolves bf16 specials and drives the philo log engine
module flog_sched
  import flog_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [16*NREQ-1:0]         req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [$clog2(NREQ)-1:0]    resp_id,
  output logic [7:0]                 resp_int,
  output logic [OUT_WIDTH_PHILO-1:0] resp_frac,
  output logic [1:0]                 resp_class,
  output logic                       resp_err,
  output logic                       busy
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT);

  ss_sched                    state;
  logic [IW-1:0]              last_grant;
  logic [IW-1:0]              gnt_idx;
  logic [NREQ-1:0]            gnt;
  logic                       gnt_any;
  logic [15:0]                op;
  logic [1:0]                 op_cls;
  logic [7:0]                 op_int;
  logic [TW-1:0]              wcnt;
  logic                       flush;
  logic                       eng_rst;
  logic                       eng_in_valid;
  logic [MAN_WIDTH_PHILO-1:0] eng_in_value;
  logic                       eng_out_valid;
  logic [OUT_WIDTH_PHILO-1:0] eng_output_value;

  flog_rr_arb #(.NREQ(NREQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx),
    .gnt_any    (gnt_any)
  );

  assign op        = req_data[{gnt_idx, 4'b0000} +: 16];
  assign op_cls    = bf16_class(op);
  assign op_int    = op[14:7] - 8'(EXP_BIAS);
  assign req_ready = (state == IDLE && !rst) ? gnt : '0;
  assign busy      = (state != IDLE);
  // A hung engine is recovered by resetting it during the single FLUSH cycle.
  assign eng_rst   = rst | flush;

  philo u_philo (
    .clk          (clk),
    .rst          (eng_rst),
    .in_valid     (eng_in_valid),
    .in_value     (eng_in_value),
    .out_valid    (eng_out_valid),
    .output_value (eng_output_value)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= IW'(NREQ-1);
      resp_valid   <= 1'b0;
      resp_id      <= '0;
      resp_int     <= '0;
      resp_frac    <= '0;
      resp_class   <= CLS_NORM;
      resp_err     <= 1'b0;
      eng_in_valid <= 1'b0;
      eng_in_value <= '0;
      flush        <= 1'b0;
      wcnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            last_grant <= gnt_idx;
            resp_id    <= gnt_idx;
            resp_class <= op_cls;
            resp_err   <= 1'b0;
            resp_frac  <= '0;
            if (op_cls == CLS_NORM) begin
              resp_int     <= op_int;
              eng_in_value <= {1'b1, op[6:0], {(MAN_WIDTH_PHILO-8){1'b0}}};
              eng_in_valid <= 1'b1;
              state        <= LAUNCH;
            end else begin
              resp_int   <= '0;
              resp_valid <= 1'b1;
              state      <= RESP;
            end
          end
        end
        LAUNCH: begin
          eng_in_valid <= 1'b0;
          wcnt         <= '0;
          state        <= WAIT;
        end
        WAIT: begin
          if (eng_out_valid) begin
            resp_frac  <= eng_output_value;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if (wcnt == TW'(TIMEOUT-1)) begin
            flush <= 1'b1;
            state <= FLUSH;
          end else begin
            wcnt <= wcnt + TW'(1);
          end
        end
        FLUSH: begin
          flush      <= 1'b0;
          resp_err   <= 1'b1;
          resp_class <= CLS_NAN;
          resp_frac  <= '0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flog_sched.sv
// tb/tb_flog_sched.sv - directed self-checking bench for flog_sched
module tb_flog_sched;
  import flog_pkg::*;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic [NREQ-1:0]            req_valid = '0;
  logic [16*NREQ-1:0]         req_data = '0;
  logic [NREQ-1:0]            req_ready;
  logic                       resp_valid;
  logic                       resp_ready = 1'b0;
  logic [1:0]                 resp_id;
  logic [7:0]                 resp_int;
  logic [OUT_WIDTH_PHILO-1:0] resp_frac;
  logic [1:0]                 resp_class;
  logic                       resp_err;
  logic                       busy;

  int n_chk = 0;
  int n_pass = 0;
  int launches = 0;

  int                         r_lat;
  logic [1:0]                 r_id;
  logic [7:0]                 r_int;
  logic [OUT_WIDTH_PHILO-1:0] r_frac;
  logic [1:0]                 r_cls;
  logic                       r_err;

  flog_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_int   (resp_int),
    .resp_frac  (resp_frac),
    .resp_class (resp_class),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dut.eng_in_valid) launches++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Called at a negedge; returns at the negedge where resp_valid is first seen.
  task automatic send(input int id, input logic [15:0] op);
    int n;
    req_data[16*id +: 16] = op;
    req_valid[id] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[id] && n < 200) begin
      @(negedge clk); #1; n++;
    end
    check("grant", req_ready[id], 1);
    @(negedge clk);
    req_valid[id] = 1'b0;
    r_lat = 1;
    while (!resp_valid && r_lat < 200) begin
      @(negedge clk); r_lat++;
    end
    r_id = resp_id; r_int = resp_int; r_frac = resp_frac; r_cls = resp_class; r_err = resp_err;
  endtask

  task automatic accept();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_clear", resp_valid, 0);
  endtask

  logic [15:0] sp_op  [5];
  logic [1:0]  sp_cls [5];
  int          sp_id  [5];

  initial begin
    int l0, k, n, diff;
    logic prev;
    sp_op  = '{16'h0000, 16'h8000, 16'h7F80, 16'h7FC0, 16'hBF80};
    sp_cls = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b11};
    sp_id  = '{1, 2, 3, 0, 3};

    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_fields", {resp_id, resp_int, resp_frac, resp_class, resp_err}, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    send(2, 16'h3F80);
    check("one_lat", r_lat, 19);
    check("one_id", r_id, 2);
    check("one_int", r_int, 0);
    check("one_frac", r_frac, 0);
    check("one_cls", r_cls, 0);
    accept();

    send(0, 16'h4040);
    diff = int'(r_frac) - 32'h95C0;
    check("three_id", r_id, 0);
    check("three_int", r_int, 1);
    check("three_frac_near", (diff >= -2 && diff <= 2), 1);
    check("three_cls", r_cls, 0);
    check("three_err", r_err, 0);
    accept();

    for (int i = 0; i < 5; i++) begin
      l0 = launches;
      send(sp_id[i], sp_op[i]);
      check("sp_lat", r_lat, 1);
      check("sp_cls", r_cls, sp_cls[i]);
      check("sp_val", {r_int, r_frac}, 0);
      accept();
      check("sp_no_launch", launches - l0, 0);
    end

    // Everyone requests at once; last grant was requester 3, so 0 goes first.
    resp_ready = 1'b1;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) req_data[16*i +: 16] = 16'h3F80;
    k = 0; n = 0; prev = 1'b0;
    while (k < 5 && n < 600) begin
      #1;
      if (prev) check("rr_pulse", req_ready, 0);
      prev = (req_ready != '0);
      if (prev) begin
        check("rr_onehot", $onehot(req_ready), 1);
        check("rr_order", oh_idx(req_ready), k % 4);
        k++;
      end
      @(negedge clk); n++;
    end
    #1;
    check("rr_pulse_last", req_ready, 0);
    req_valid = '0;
    check("rr_grants", k, 5);
    n = 0;
    while (!resp_valid && n < 100) begin @(negedge clk); n++; end
    check("rr_last_resp", resp_valid, 1);
    check("rr_last_id", resp_id, 0);
    @(negedge clk);
    resp_ready = 1'b0;

    // Backpressure with requester 2 waiting behind requester 1.
    req_data[32 +: 16] = 16'h0000;
    req_valid[2] = 1'b1;
    send(1, 16'h7F80);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", {resp_valid, resp_id, resp_class, resp_err, resp_int, resp_frac},
            {1'b1, 2'd1, 2'b10, 1'b0, 8'd0, 16'd0});
      check("bp_no_grant", req_ready, 0);
      @(negedge clk);
    end
    accept();
    #1;
    check("bp_next_grant", req_ready, 4'b0100);
    @(negedge clk);
    req_valid[2] = 1'b0;
    check("bp_req2_resp", {resp_valid, resp_id, resp_class}, {1'b1, 2'd2, 2'b01});
    accept();

    // Asynchronous reset while the engine is mid-computation.
    req_data[48 +: 16] = 16'h4040;
    req_valid[3] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[3] && n < 200) begin @(negedge clk); #1; n++; end
    check("mid_grant", req_ready[3], 1);
    @(negedge clk);
    req_valid[3] = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", resp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_fields", {resp_id, resp_int, resp_frac, resp_class, resp_err}, 0);
    check("mid_rst_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(1, 16'h4000);
    check("two_lat", r_lat, 19);
    check("two_id", r_id, 1);
    check("two_int", r_int, 1);
    check("two_frac", r_frac, 0);
    accept();

    // Engine never answers: timeout, flush, error response.
    force dut.eng_out_valid = 1'b0;
    send(3, 16'h4040);
    release dut.eng_out_valid;
    check("to_lat", r_lat, TIMEOUT + 3);
    check("to_err", r_err, 1);
    check("to_cls", r_cls, 2'b11);
    check("to_frac", r_frac, 0);
    accept();

    send(0, 16'h4040);
    check("after_to_lat", r_lat, 19);
    check("after_to_err", r_err, 0);
    check("after_to_int", r_int, 1);
    accept();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
